mem_1r1w_rd_port: RTL and testbench

Decoupled read front-end for the `mem_1r1w` SRAM wrapper (48 x 64, synchronous read, 1-cycle latency). Accepts read requests on a valid/ready channel, drives the wrapper's `R0_*` port, and returns data in request order on a valid/ready response channel.
- Provides full-rate streaming and tolerates arbitrary response backpressure without losing in-flight data.
- Flags out-of-range addresses as errors without touching the macro.

---
 rtl/mem_rd_pkg.sv | 14 +
 rtl/rd_resp_fifo.sv | 56 +++++
 rtl/mem_1r1w_rd_port.sv | 90 +++++++++
 tb/tb_mem_1r1w_rd_port.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_pkg.sv
// Shared defaults and the response-entry payload for the mem_1r1w read front-end.
package mem_rd_pkg;

    localparam int unsigned DFLT_ADDR_W    = 6;
    localparam int unsigned DFLT_DATA_W    = 64;
    localparam int unsigned DFLT_MEM_DEPTH = 48;

    // One buffered response: read data (zero on error) plus error flag.
    typedef struct packed {
        logic [DFLT_DATA_W-1:0] data;
        logic                   err;
    } rd_entry_t;

endpackage

// File: rtl/rd_resp_fifo.sv
// Response buffer for the read front-end: DEPTH-entry synchronous FIFO of rd_entry_t.
// Ports:
//   clock, reset_n  clock and async active-low reset
//   push, push_entry  write an entry (caller guarantees a free slot)
//   pop               retire the head entry (caller guarantees non-empty)
//   head              current head entry (no bypass: a push is visible next cycle)
//   count             occupancy, 0..DEPTH
module rd_resp_fifo
    import mem_rd_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  rd_entry_t        push_entry,
    input  logic             pop,
    output rd_entry_t        head,
    output logic [CNT_W-1:0] count
);

    rd_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Storage, pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr] <= push_entry;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = mem_q[rd_ptr];

endmodule

// File: rtl/mem_1r1w_rd_port.sv
// Decoupled read front-end for the mem_1r1w SRAM wrapper (synchronous read, 1-cycle latency).
// Requests arrive on a valid/ready channel, drive the R0 port directly, and return in order
// on a valid/ready response channel after passing through a small credit-managed buffer.
// BUF_DEPTH must be >= 2 for full-rate streaming.
// Ports:
//   clock, reset_n           clock (also the wrapper's R0_clk) and async active-low reset
//   req_valid/ready/addr     request channel
//   resp_valid/ready/data/err  response channel; data is 0 and err is 1 for out-of-range
//   R0_addr, R0_en, R0_data  wrapper read port; R0_data is valid the cycle after R0_en
module mem_1r1w_rd_port
    import mem_rd_pkg::*;
#(
    parameter int unsigned ADDR_W    = DFLT_ADDR_W,
    parameter int unsigned DATA_W    = DFLT_DATA_W,
    parameter int unsigned MEM_DEPTH = DFLT_MEM_DEPTH,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] R0_addr,
    output logic              R0_en,
    input  logic [DATA_W-1:0] R0_data
);

    localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PEND_W = CNT_W + 1;

    logic             acc;
    logic             in_range;
    logic             pop;
    logic             infl_v;
    logic             infl_err;
    logic [CNT_W-1:0] count;
    logic [PEND_W-1:0] pending;
    rd_entry_t        push_entry;
    rd_entry_t        head;

    // Range check, accept, and read issue; out-of-range accepts never touch the macro.
    assign in_range = 32'(req_addr) < MEM_DEPTH;
    assign acc      = req_valid && req_ready;
    assign R0_addr  = req_addr;
    assign R0_en    = acc && in_range;

    // Credit: occupancy after this cycle's pop, plus the word landing next cycle, must leave a slot.
    assign pop       = resp_valid && resp_ready;
    assign pending   = PEND_W'(count) + PEND_W'(infl_v) - PEND_W'(pop);
    assign req_ready = pending < PEND_W'(BUF_DEPTH);

    // In-flight stage tracks the accept whose read data arrives this cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            infl_v   <= 1'b0;
            infl_err <= 1'b0;
        end else begin
            infl_v   <= acc;
            infl_err <= acc && !in_range;
        end
    end

    // Error responses carry zero data instead of whatever R0_data holds.
    always_comb begin
        push_entry      = '0;
        push_entry.err  = infl_err;
        push_entry.data = infl_err ? '0 : DFLT_DATA_W'(R0_data);
    end

    rd_resp_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (infl_v),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    assign resp_valid = (count != '0);
    assign resp_data  = DATA_W'(head.data);
    assign resp_err   = head.err;

endmodule

// File: tb/tb_mem_1r1w_rd_port.sv
// Scoreboard bench for mem_1r1w_rd_port with a behavioural 1-cycle SRAM model.
module tb_mem_1r1w_rd_port;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned MEM_DEPTH = 48;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_err;
    logic [5:0]  R0_addr;
    logic        R0_en;
    logic [63:0] R0_data;

    mem_1r1w_rd_port #(
        .ADDR_W    (6),
        .DATA_W    (64),
        .MEM_DEPTH (MEM_DEPTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .R0_addr    (R0_addr),
        .R0_en      (R0_en),
        .R0_data    (R0_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic [63:0] mem [64];
    exp_t        q [$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    int          n_pop = 0;
    bit          strict_lat = 1'b0;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = {16'hC0DE, 16'(i), 32'(i) * 32'h0101_0101};
        end
        mem[5] = 64'hDEAD_BEEF_0000_0005;
    end

    // SRAM model: data appears the cycle after R0_en, garbage otherwise.
    always @(posedge clock) begin
        R0_data <= R0_en ? mem[R0_addr] : {$urandom, $urandom};
        cyc     <= cyc + 1;
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stimulus side: read-port checks and expected-response push on each accept.
    always @(negedge clock) begin
        if (reset_n) begin
            check1("r0_en", R0_en, req_valid && req_ready && (int'(req_addr) < int'(MEM_DEPTH)));
            if (R0_en) check64("r0_addr", 64'(R0_addr), 64'(req_addr));
            if (req_valid && req_ready) begin
                exp_t e;
                e.err  = !(int'(req_addr) < int'(MEM_DEPTH));
                e.data = e.err ? 64'd0 : mem[req_addr];
                e.cyc  = cyc;
                q.push_back(e);
                n_acc++;
            end
        end
    end

    // Monitor: pop and compare whenever a response is handed over.
    always @(negedge clock) begin
        if (!reset_n) begin
            q.delete();
            n_pop = n_acc;
        end else begin
            if (q.size() == 0) check1("no_spurious_resp", resp_valid, 1'b0);
            if (resp_valid && resp_ready && q.size() > 0) begin
                exp_t e;
                int   lat;
                e   = q.pop_front();
                lat = cyc - e.cyc;
                n_pop++;
                check64("resp_data", resp_data, e.data);
                check1("resp_err", resp_err, e.err);
                if (strict_lat) check64("latency", 64'(lat), 64'd2);
                else            check64("latency_min", 64'(lat >= 2 ? 2 : lat), 64'd2);
            end
        end
    end

    // Accepted-but-unreturned requests never exceed the buffer size.
    always @(posedge clock) begin
        #2;
        if (reset_n) check1("outstanding_bound", (n_acc - n_pop) <= int'(BUF_DEPTH), 1'b1);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Offer one request; returns the number of cycles req_ready was low.
    task automatic send(input logic [5:0] a, output int waits);
        bit ok;
        ok        = 1'b0;
        waits     = 0;
        req_valid = 1'b1;
        req_addr  = a;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: addr %0d never accepted, required acceptance within 100 cycles", a);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %0d responses still pending, required 0", name, q.size());
        end
    endtask

    initial begin
        int  w;
        bit  rand_on;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;

        // Reset values
        #12;
        check1("rst_resp_valid", resp_valid, 1'b0);
        check1("rst_resp_err", resp_err, 1'b0);
        check64("rst_resp_data", resp_data, 64'd0);
        check1("rst_r0_en", R0_en, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        check1("rst_req_ready", req_ready, 1'b1);

        // Single read of addr 5
        strict_lat = 1'b1;
        resp_ready = 1'b1;
        idle(1);
        send(6'd5, w);
        check64("single_waits", 64'(w), 64'd0);
        idle(4);

        // Streaming 0..47 with req_ready held high
        for (int a = 0; a < 48; a++) begin
            send(6'(a), w);
            check64("stream_waits", 64'(w), 64'd0);
        end
        drain("stream_drain");

        // Backpressure: only two accepted while resp_ready is low
        strict_lat = 1'b0;
        resp_ready = 1'b0;
        send(6'd1, w);
        check64("bp_waits1", 64'(w), 64'd0);
        send(6'd2, w);
        check64("bp_waits2", 64'(w), 64'd0);
        req_valid = 1'b1;
        req_addr  = 6'd3;
        repeat (3) begin
            @(negedge clock);
            check1("bp_ready_low", req_ready, 1'b0);
        end
        @(posedge clock);
        #1;
        resp_ready = 1'b1;
        @(negedge clock);
        check1("bp_ready_rise", req_ready, 1'b1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        drain("bp_drain");

        // Out-of-range request between two in-range ones
        strict_lat = 1'b1;
        send(6'd10, w);
        send(6'd50, w);
        send(6'd11, w);
        drain("oor_drain");

        // Random backpressure with random in-range requests
        strict_lat = 1'b0;
        rand_on    = 1'b1;
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    send(6'($urandom_range(0, MEM_DEPTH - 1)), w);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clock);
                    #1;
                    resp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        resp_ready = 1'b1;
        drain("rand_drain");

        // Reset with one read in flight and one response buffered
        resp_ready = 1'b0;
        send(6'd20, w);
        send(6'd21, w);
        idle(1);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 6'd22;
        @(negedge clock);
        check1("rst_pre_ready", req_ready, 1'b1);
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        reset_n    = 1'b0;
        #1;
        check1("midrst_resp_valid", resp_valid, 1'b0);
        check64("midrst_resp_data", resp_data, 64'd0);
        check1("midrst_resp_err", resp_err, 1'b0);
        check1("midrst_req_ready", req_ready, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        reset_n    = 1'b1;
        resp_ready = 1'b1;
        idle(5);
        strict_lat = 1'b1;
        send(6'd7, w);
        check64("post_rst_waits", 64'(w), 64'd0);
        drain("post_rst_drain");
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
